mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- Register file for the MIPS demo datapath, sitting directly upstream of the ALU.
- Two combinational read ports drive the ALU operand inputs; one synchronous write port accepts write-back results.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass, so write-back and decode can share a cycle without a stall.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- BYPASS, 1, 1 = a read of the register being written returns WriteData in the same cycle; 0 = the read returns the old stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- RegWrite  input  1  write enable, sampled at the rising edge of clk.
- WriteReg  input  ADDR_W  destination register index.
- WriteData  input  DATA_W  data to write.
- ReadReg1  input  ADDR_W  source index for port 1 (rs).
- ReadReg2  input  ADDR_W  source index for port 2 (rt).
- ReadData1  output  DATA_W  contents of ReadReg1; feeds ALU operand A.
- ReadData2  output  DATA_W  contents of ReadReg2; feeds ALU operand B (before the immediate mux).

Behaviour:
- Storage: array of 2**ADDR_W words of DATA_W bits.
- Entry 0 is never written and always reads 0.
- Reset:
  - When rst rises, every entry clears to 0 immediately, without waiting for a clock edge.
  - While rst is high, ReadData1 and ReadData2 are 0 and writes are ignored.
  - Bypass is suppressed while rst is high.
- Write:
  - At a rising clk edge with rst=0, RegWrite=1 and WriteReg!=0, the entry at WriteReg takes WriteData.
  - Latency is 1 cycle: the new value is visible from storage after that edge.
  - RegWrite=1 with WriteReg=0 is a no-op.
  - RegWrite=0 leaves all entries unchanged.
- Read:
  - Fully combinational, zero-cycle latency.
  - ReadDataN = 0 if ReadRegN==0; otherwise the stored entry.
- Bypass, when BYPASS=1:
  - If RegWrite=1, WriteReg!=0, rst=0 and WriteReg==ReadRegN, then ReadDataN = WriteData in the same cycle.
  - This applies to each port independently.
- Bypass, when BYPASS=0: the read returns the pre-edge stored value until the edge commits the write.
- Both read ports may address the same register; both return identical data, bypassed or not.
- Reset mid-operation:
  - rst asserted in the same cycle as a pending write: the write is lost and the entry stays 0.
  - After rst deasserts, the first write takes effect at the next rising edge.
- No handshake: the file is always ready and never stalls.
- Every output is a pure function of the current inputs and storage state. No latches; reads have no clock dependency.

Test Plan:
- Reset: preload r5=0x12345678, assert rst mid-cycle -> ReadData1 (ReadReg1=5) goes 0 without a clock edge; stays 0 after rst deasserts.
- Basic write/read: write r7=0xDEADBEEF, next cycle ReadReg1=7, ReadReg2=7 -> both ports read 0xDEADBEEF.
- r0 protection: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, next cycle ReadReg1=0 -> ReadData1=0.
- Bypass (BYPASS=1): r9=0x1; same cycle write r9=0xA5A5A5A5 with ReadReg2=9 -> ReadData2=0xA5A5A5A5 before the edge; ReadReg1=8 is unaffected.
- Bypass off (BYPASS=0): same stimulus -> ReadData2=0x1 before the edge, 0xA5A5A5A5 after it.
- Write with reset: RegWrite=1, WriteReg=3, WriteData=0x55 while rst=1 -> after release, r3 reads 0. Then an ALU pairing check: r1=10, r2=3 feed an ALU subtract -> ALU_result=7.

Source files
------------

// File: rtl/mips_reg_file_if.sv
// Register-file access bundle: one write port and two read ports.
// The master (decode / write-back side) drives indices and data; the file answers on ReadData1/2.
interface mips_reg_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/mips_reg_file.sv
// MIPS register file: two combinational read ports, one synchronous write port, r0 tied to zero,
// optional same-cycle write-to-read bypass and asynchronous active-high clear.
module mips_reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input logic            clk,
    input logic            rst,
    mips_reg_file_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;
    logic              byp_en;

    // Writes to r0 are dropped here so r0 storage stays at its reset value of zero.
    assign wr_en  = bus.RegWrite && (bus.WriteReg != '0);
    assign byp_en = (BYPASS != 0) && wr_en && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.WriteReg] <= bus.WriteData;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!rst && addr != '0) begin
            val = regs_q[addr];
            if (byp_en && bus.WriteReg == addr) begin
                val = bus.WriteData;
            end
        end
        return val;
    endfunction

    always_comb begin
        bus.ReadData1 = read_port(bus.ReadReg1);
        bus.ReadData2 = read_port(bus.ReadReg2);
    end
endmodule

// File: tb/tb_mips_reg_file.sv
// Scoreboard bench for mips_reg_file: drives a BYPASS=1 and a BYPASS=0 instance in lockstep and
// checks both read ports against an array model of the register file.
module tb_mips_reg_file;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [95:0]   name;
        logic          alu;
        logic [DW-1:0] e1b;
        logic [DW-1:0] e2b;
        logic [DW-1:0] e1n;
        logic [DW-1:0] e2n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] wr = '0;
    logic [DW-1:0] wd = '0;
    logic [AW-1:0] r1 = '0;
    logic [AW-1:0] r2 = '0;

    logic [DW-1:0] model [2**AW];
    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    always #5 clk = ~clk;

    mips_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    mips_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

    assign bus_b.RegWrite  = we;
    assign bus_b.WriteReg  = wr;
    assign bus_b.WriteData = wd;
    assign bus_b.ReadReg1  = r1;
    assign bus_b.ReadReg2  = r2;
    assign bus_n.RegWrite  = we;
    assign bus_n.WriteReg  = wr;
    assign bus_n.WriteData = wd;
    assign bus_n.ReadReg1  = r1;
    assign bus_n.ReadReg2  = r2;

    mips_reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    mips_reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n.slave)
    );

    // What a read of address a must return right now, given the committed model contents.
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return '0;
        if (byp && we && wr != 0 && wr == a) return wd;
        return model[a];
    endfunction

    task automatic chk(input logic [95:0] nm, input string what, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s %0s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // One cycle: commit the previous cycle's write to the model at the edge, then apply new inputs
    // and queue the expected outputs.
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [95:0] nm, input logic alu = 1'b0);
        exp_t e;
        @(posedge clk);
        if (!rst && we && wr != 0) model[wr] = wd;
        #2;
        rst = r; we = w; wr = a; wd = d; r1 = ra; r2 = rb;
        if (r) begin
            for (int i = 0; i < 2**AW; i++) model[i] = '0;
        end
        e.name = nm;
        e.alu  = alu;
        e.e1b  = ref_read(ra, 1'b1);
        e.e2b  = ref_read(rb, 1'b1);
        e.e1n  = ref_read(ra, 1'b0);
        e.e2n  = ref_read(rb, 1'b0);
        sb_q.push_back(e);
        pushed++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            popped++;
            chk(e.name, "byp rd1", bus_b.ReadData1, e.e1b);
            chk(e.name, "byp rd2", bus_b.ReadData2, e.e2b);
            chk(e.name, "nobyp rd1", bus_n.ReadData1, e.e1n);
            chk(e.name, "nobyp rd2", bus_n.ReadData2, e.e2n);
            if (e.alu) chk(e.name, "alu sub", bus_b.ReadData1 - bus_b.ReadData2, e.e1b - e.e2b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a, ra, rb;
        for (int i = 0; i < 2**AW; i++) model[i] = '0;

        drive(1, 0, 0, 0, 5, 31, "reset");
        drive(0, 1, 5, 32'h1234_5678, 0, 1, "preload");
        drive(0, 0, 0, 0, 5, 5, "r5 readback");
        drive(1, 0, 0, 0, 5, 5, "async rst");
        drive(0, 0, 0, 0, 5, 5, "post rst");

        drive(0, 1, 7, 32'hDEAD_BEEF, 0, 0, "write r7");
        drive(0, 0, 0, 0, 7, 7, "read r7");

        drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, "write r0");
        drive(0, 0, 0, 0, 0, 0, "read r0");

        drive(0, 1, 9, 32'h1, 0, 0, "r9 init");
        drive(0, 1, 9, 32'hA5A5_A5A5, 8, 9, "bypass");
        drive(0, 0, 0, 0, 8, 9, "after edge");

        drive(1, 1, 3, 32'h55, 3, 3, "wr in rst");
        drive(0, 0, 0, 0, 3, 3, "r3 zero");

        drive(0, 1, 1, 32'd10, 0, 0, "r1=10");
        drive(0, 1, 2, 32'd3, 1, 2, "r2 byp");
        drive(0, 0, 0, 0, 1, 2, "alu pair", 1'b1);

        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra = ($urandom_range(0, 1) != 0) ? a : AW'($urandom_range(0, 7));
            rb = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 7));
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) != 0, a, $urandom, ra, rb,
                  "random", 1'b1);
        end

        drive(0, 0, 0, 0, 0, 0, "idle");
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: got popped %0d left %0d expected popped %0d left 0",
                     popped, sb_q.size(), pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
